whack_judge: RTL
================

Name: whack_judge

Overview:
- Player-side counterpart of the mole generator.
- Watches the current mole position and the 18 player switches, and decides hit, wrong-hole miss or timeout.
- Drives `mole_hit` back to the generator so the mole clears, and keeps the running score and miss count.
- Sits between the random-mole block and the score display.

Parameters:
- NUM_HOLES, 18, number of holes/switches; valid positions are 0..NUM_HOLES-1.
- TIMEOUT_TICKS, 1500, `tick` pulses a mole stays up before it counts as a timeout miss.
- COOLDOWN_CYC, 4, clk cycles after any verdict during which switch edges are ignored.
- SCORE_W, 10, score counter width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- position  in  5  current mole index; any value >= NUM_HOLES means no mole.
- sw  in  NUM_HOLES  raw player switches, asynchronous to clk.
- tick  in  1  one-cycle timebase strobe (1 ms).
- mole_hit  out  1  one-cycle pulse that clears the mole; connects to the generator's `mole_hit`.
- hit_pulse  out  1  one-cycle pulse on a correct hit.
- miss_pulse  out  1  one-cycle pulse on a wrong hole or a timeout.
- timeout_pulse  out  1  one-cycle pulse on a timeout only.
- score  out  SCORE_W  correct hits, saturating.
- misses  out  8  total misses, saturating at 255.

Behaviour:
- Switch input path:
  - `sw` passes through a 2-flop synchroniser, then a previous-value register.
  - rise[i] = sync[i] & ~prev[i].
  - A switch sampled high at clk edge k gives rise[i] at edge k+2.
- FSM states: IDLE, ARMED, REPORT, COOLDOWN.
- IDLE:
  - Timer held at 0; rises are ignored.
  - When position < NUM_HOLES, go to ARMED next cycle.
- ARMED:
  - Timer increments on each `tick`.
  - Correct hit: rise[position] = 1. Set verdict = HIT and go to REPORT.
  - Wrong hole: any other rise bit set while rise[position] = 0. Set verdict = WRONG and go to REPORT.
  - Timeout: timer reaches TIMEOUT_TICKS. Set verdict = TIMEOUT and go to REPORT.
  - Priority when events coincide in one cycle: HIT > WRONG > TIMEOUT.
  - If position becomes invalid while ARMED (generator reset), return to IDLE with no verdict.
- REPORT (exactly one cycle):
  - mole_hit = 1 for HIT and TIMEOUT; 0 for WRONG (the mole stays up and the timer continues).
  - HIT: hit_pulse = 1; score += 1, saturating at 2^SCORE_W-1.
  - WRONG or TIMEOUT: miss_pulse = 1; misses += 1, saturating at 255.
  - TIMEOUT additionally asserts timeout_pulse.
  - Next state is COOLDOWN.
- COOLDOWN:
  - Counts COOLDOWN_CYC cycles; rises are discarded.
  - Then goes to ARMED if the verdict was WRONG and position is still valid; otherwise to IDLE.
  - IDLE then waits for the next valid position.
- Latency: switch high at edge k → mole_hit and hit_pulse high during the cycle after edge k+3.
- All pulse outputs are registered and last exactly one cycle.
- Reset:
  - All outputs go to 0; state = IDLE; timer, cooldown, score and misses cleared; synchroniser and prev flops cleared.
  - Reset mid-REPORT suppresses the pulse.
- A switch held high generates only one rise; it must be released and pressed again.

Optional Feature:
- Macro: STREAK_EN.
- When defined:
  - Adds output `streak` (out, 4 bits), which counts consecutive HITs, saturating at 15 and clearing to 0 on any miss.
  - A HIT with streak >= 3 (value before the increment) adds 2 to score instead of 1, still saturating.
- When undefined: no `streak` port, and every HIT adds 1.

Decomposition:
- Package whack_pkg holds:
  - state enum {IDLE, ARMED, REPORT, COOLDOWN};
  - verdict enum {HIT, WRONG, TIMEOUT};
  - constants NUM_HOLES_DEF = 18 and POS_NONE = 5'd31.
- One sub-module, sw_edge_sync: per-bit 2-flop synchroniser plus rising-edge detector, NUM_HOLES wide.

Test Plan:
- position=7, sw[7] raised once → one mole_hit/hit_pulse pulse 4 cycles later; score 0→1; misses stays 0.
- position=7, sw[3] raised → miss_pulse, misses=1, mole_hit stays 0; after cooldown sw[7] raised → hit, score=1.
- position=12, no input, 1500 ticks → timeout_pulse, miss_pulse and mole_hit in the same cycle; misses=1.
- sw[5] and sw[9] rise in the same cycle with position=9 → HIT only, misses unchanged; sw[9] held high for 100 cycles → single hit.
- Score preloaded to 1023 via repeated hits, one more hit → score stays 1023; reset asserted during REPORT → no pulse, all counters 0.
- STREAK_EN: 4 consecutive hits → score 1,2,3,5 and streak=4; then a wrong hole → streak=0.

Source files
------------

// File: rtl/whack_pkg.sv
// Shared types and constants for the whack-a-mole judge slice.
package whack_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        REPORT   = 2'd2,
        COOLDOWN = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        HIT     = 2'd0,
        WRONG   = 2'd1,
        TIMEOUT = 2'd2
    } verdict_e;

    localparam int         NUM_HOLES_DEF = 18;
    localparam logic [4:0] POS_NONE      = 5'd31;

    // Saturating 8-bit increment used by the miss counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'hFF) begin
            r = 8'hFF;
        end else begin
            r = v + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/sw_edge_sync.sv
// Per-bit 2-flop synchroniser followed by a rising-edge detector.
module sw_edge_sync #(
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] meta_r;
    logic [WIDTH-1:0] sync_r;
    logic [WIDTH-1:0] prev_r;

    // Synchroniser chain plus previous-value register.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_r <= {WIDTH{1'b0}};
            sync_r <= {WIDTH{1'b0}};
            prev_r <= {WIDTH{1'b0}};
        end else begin
            meta_r <= sw;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign rise = sync_r & ~prev_r;

endmodule

// File: rtl/whack_judge.sv
// Whack-a-mole judge: decides hit / wrong-hole / timeout and keeps score.
// Optional macro STREAK_EN adds a consecutive-hit streak with bonus scoring.
module whack_judge
    import whack_pkg::*;
#(
    parameter int NUM_HOLES     = NUM_HOLES_DEF,
    parameter int TIMEOUT_TICKS = 1500,
    parameter int COOLDOWN_CYC  = 4,
    parameter int SCORE_W       = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [4:0]           position,
    input  logic [NUM_HOLES-1:0] sw,
    input  logic                 tick,
    output logic                 mole_hit,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
    output logic                 timeout_pulse,
    output logic [SCORE_W-1:0]   score,
    output logic [7:0]           misses
`ifdef STREAK_EN
    ,
    output logic [3:0]           streak
`endif
);

    localparam int TIMER_W = $clog2(TIMEOUT_TICKS + 1);
    localparam int CD_W    = $clog2(COOLDOWN_CYC + 1);
    localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT_TICKS);
    localparam logic [TIMER_W-1:0] TIMER_MAX   = {TIMER_W{1'b1}};
    localparam logic [CD_W-1:0]    CD_LAST     = CD_W'(COOLDOWN_CYC - 1);

    state_e               state_r, state_s;
    verdict_e             verdict_r, verdict_s;
    logic [TIMER_W-1:0]   timer_r;
    logic [CD_W-1:0]      cd_r;
    logic [NUM_HOLES-1:0] rise_s;
    logic [NUM_HOLES-1:0] pos_mask_s;
    logic                 pos_valid_s;
    logic                 hit_s, wrong_s;
    logic [1:0]           score_inc_s;

    logic                 mole_hit_r, hit_pulse_r, miss_pulse_r, timeout_pulse_r;
    logic [SCORE_W-1:0]   score_r;
    logic [7:0]           misses_r;

    function automatic logic [SCORE_W-1:0] score_add(input logic [SCORE_W-1:0] v,
                                                      input logic [1:0]         inc);
        logic [SCORE_W:0] sum;
        sum = {1'b0, v} + {{(SCORE_W-1){1'b0}}, inc};
        return sum[SCORE_W] ? {SCORE_W{1'b1}} : sum[SCORE_W-1:0];
    endfunction

    sw_edge_sync #(.WIDTH(NUM_HOLES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .sw    (sw),
        .rise  (rise_s)
    );

    assign pos_valid_s = (position != POS_NONE) && (32'(position) < 32'(NUM_HOLES));
    assign pos_mask_s  = {{(NUM_HOLES-1){1'b0}}, 1'b1} << position;
    assign hit_s       = |(rise_s & pos_mask_s);
    assign wrong_s     = |(rise_s & ~pos_mask_s);

    // State and verdict registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= IDLE;
            verdict_r <= HIT;
        end else begin
            state_r   <= state_s;
            verdict_r <= verdict_s;
        end
    end

    // Next-state and verdict selection; HIT outranks WRONG outranks TIMEOUT.
    always_comb begin
        state_s   = state_r;
        verdict_s = verdict_r;
        case (state_r)
            IDLE: begin
                if (pos_valid_s) begin
                    state_s = ARMED;
                end else begin
                    state_s = IDLE;
                end
            end
            ARMED: begin
                if (!pos_valid_s) begin
                    state_s = IDLE;
                end else if (hit_s) begin
                    state_s   = REPORT;
                    verdict_s = HIT;
                end else if (wrong_s) begin
                    state_s   = REPORT;
                    verdict_s = WRONG;
                end else if (timer_r >= TIMER_LIMIT) begin
                    state_s   = REPORT;
                    verdict_s = TIMEOUT;
                end else begin
                    state_s = ARMED;
                end
            end
            REPORT: begin
                state_s = COOLDOWN;
            end
            COOLDOWN: begin
                if (cd_r != CD_LAST) begin
                    state_s = COOLDOWN;
                end else if ((verdict_r == WRONG) && pos_valid_s) begin
                    state_s = ARMED;
                end else begin
                    state_s = IDLE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Mole timer keeps running through a wrong-hole cooldown; cleared only in IDLE.
    always_ff @(posedge clk) begin
        if (reset || (state_r == IDLE)) begin
            timer_r <= {TIMER_W{1'b0}};
        end else if (tick && (timer_r != TIMER_MAX)) begin
            timer_r <= timer_r + {{(TIMER_W-1){1'b0}}, 1'b1};
        end else begin
            timer_r <= timer_r;
        end
    end

    // Cooldown cycle counter.
    always_ff @(posedge clk) begin
        if (reset || (state_r != COOLDOWN)) begin
            cd_r <= {CD_W{1'b0}};
        end else begin
            cd_r <= cd_r + {{(CD_W-1){1'b0}}, 1'b1};
        end
    end

`ifdef STREAK_EN
    logic [3:0] streak_r;

    assign score_inc_s = (streak_r >= 4'd3) ? 2'd2 : 2'd1;
    assign streak      = streak_r;

    // Consecutive-hit streak: saturates at 15, cleared by any miss.
    always_ff @(posedge clk) begin
        if (reset) begin
            streak_r <= 4'd0;
        end else if ((state_r == REPORT) && (verdict_r == HIT)) begin
            streak_r <= (streak_r == 4'd15) ? 4'd15 : streak_r + 4'd1;
        end else if (state_r == REPORT) begin
            streak_r <= 4'd0;
        end else begin
            streak_r <= streak_r;
        end
    end
`else
    assign score_inc_s = 2'd1;
`endif

    // Registered verdict pulses and saturating counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            mole_hit_r      <= 1'b0;
            hit_pulse_r     <= 1'b0;
            miss_pulse_r    <= 1'b0;
            timeout_pulse_r <= 1'b0;
            score_r         <= {SCORE_W{1'b0}};
            misses_r        <= 8'd0;
        end else begin
            mole_hit_r      <= (state_r == REPORT) && (verdict_r != WRONG);
            hit_pulse_r     <= (state_r == REPORT) && (verdict_r == HIT);
            miss_pulse_r    <= (state_r == REPORT) && (verdict_r != HIT);
            timeout_pulse_r <= (state_r == REPORT) && (verdict_r == TIMEOUT);
            if ((state_r == REPORT) && (verdict_r == HIT)) begin
                score_r  <= score_add(score_r, score_inc_s);
                misses_r <= misses_r;
            end else if (state_r == REPORT) begin
                score_r  <= score_r;
                misses_r <= sat_inc8(misses_r);
            end else begin
                score_r  <= score_r;
                misses_r <= misses_r;
            end
        end
    end

    assign mole_hit      = mole_hit_r;
    assign hit_pulse     = hit_pulse_r;
    assign miss_pulse    = miss_pulse_r;
    assign timeout_pulse = timeout_pulse_r;
    assign score         = score_r;
    assign misses        = misses_r;

endmodule
